// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder sequencer: FSM state
// encoding, slice width and the width of the slice index.
package nibble_serial_adder_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slice index width: clog2 of the slice count, never narrower than one bit.
  function automatic int idx_width(input int nibbles);
    return (nibbles > 2) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_adder.sv
// Combinational 4-bit adder slice with carry-in. Besides the carry out of
// bit 3 it exposes the carry into bit 3, which the controller needs to form
// signed overflow on the most significant slice.
module nibble_adder_ci
  import nibble_serial_adder_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout,
  output logic                c3
);

  logic [NIBBLE_W:0]   full_sum;
  logic [NIBBLE_W-1:0] low_sum;

  // Full 4-bit sum; the extra bit is the slice carry-out.
  assign full_sum = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};

  // Sum of the three low bits only; its top bit is the carry into bit 3.
  assign low_sum  = {1'b0, a[NIBBLE_W-2:0]} + {1'b0, b[NIBBLE_W-2:0]}
                  + {{(NIBBLE_W-1){1'b0}}, cin};

  assign s    = full_sum[NIBBLE_W-1:0];
  assign cout = full_sum[NIBBLE_W];
  assign c3   = low_sum[NIBBLE_W-1];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-nibble adder that reuses one 4-bit slice adder, one nibble per
// clock, LSB first. Operands arrive on a valid/ready request port and the
// W+1-bit sum plus signed overflow leave on a valid/ready result port.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_valid,
  output logic                          start_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]   a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   b,
  input  logic                          cin,
  input  logic                          abort,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic [NIBBLE_W*NIBBLES:0]     sum,
  output logic                          ovf,
  output logic                          busy
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int SW = W + 1;
  localparam int IW = idx_width(NIBBLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  state_t              state;
  logic [IW-1:0]       idx;
  logic                carry;
  logic [W-1:0]        a_r;
  logic [W-1:0]        b_r;

  logic [NIBBLE_W-1:0] a_sl;
  logic [NIBBLE_W-1:0] b_sl;
  logic [NIBBLE_W-1:0] s_sl;
  logic                cout_sl;
  logic                c3_sl;
  int                  shamt;

  // Slice mux: select the current nibble of each operand by shifting it down.
  assign shamt = int'(idx) * NIBBLE_W;
  assign a_sl  = NIBBLE_W'(a_r >> shamt);
  assign b_sl  = NIBBLE_W'(b_r >> shamt);

  nibble_adder_ci u_slice (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry),
    .s    (s_sl),
    .cout (cout_sl),
    .c3   (c3_sl)
  );

  // Sequencer: accept in IDLE, add one slice per cycle in RUN, hold in DONE.
  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      carry        <= 1'b0;
      a_r          <= '0;
      b_r          <= '0;
      sum          <= '0;
      ovf          <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      start_ready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          start_ready <= 1'b1;
          if (start_valid && start_ready) begin
            a_r         <= a;
            b_r         <= b;
            carry       <= cin;
            idx         <= '0;
            sum         <= '0;
            ovf         <= 1'b0;
            start_ready <= 1'b0;
            busy        <= 1'b1;
            state       <= RUN;
          end
        end

        RUN: begin
          if (abort) begin
            // Cancel wins over completion; nothing of the partial sum survives.
            idx         <= '0;
            carry       <= 1'b0;
            sum         <= '0;
            ovf         <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
            state       <= IDLE;
          end else begin
            carry <= cout_sl;
            if (idx == LAST_IDX) begin
              // Sum was cleared at accept, so OR-ing places each nibble.
              sum          <= sum | (SW'(s_sl) << shamt) | (SW'(cout_sl) << W);
              ovf          <= c3_sl ^ cout_sl;
              idx          <= '0;
              result_valid <= 1'b1;
              state        <= DONE;
            end else begin
              sum <= sum | (SW'(s_sl) << shamt);
              idx <= idx + IW'(1);
            end
          end
        end

        DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            start_ready  <= 1'b1;
            state        <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          start_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
